// File: rtl/vga_timing_if.sv
// Raster output bundle of vga_timing together with its pattern-select inputs.
// The generator drives the video side through 'master'; a consumer uses 'slave'.
interface vga_timing_if #(
  parameter int COLOR_W = 3,
  parameter int X_W     = 10,
  parameter int Y_W     = 10
);
  logic [1:0]           mode;
  logic [3*COLOR_W-1:0] solid_rgb;
  logic [COLOR_W-1:0]   red;
  logic [COLOR_W-1:0]   green;
  logic [COLOR_W-1:0]   blue;
  logic                 hsync;
  logic                 vsync;
  logic                 blank;
  logic [X_W-1:0]       x;
  logic [Y_W-1:0]       y;
  logic                 frame_start;

  modport master (
    input  mode, solid_rgb,
    output red, green, blue, hsync, vsync, blank, x, y, frame_start
  );

  modport slave (
    output mode, solid_rgb,
    input  red, green, blue, hsync, vsync, blank, x, y, frame_start
  );
endinterface

// File: rtl/vga_timing.sv
// Raster timing and test-pattern generator; every output is registered and shows
// the pixel the (hc, vc) counters held one clock earlier.
module vga_timing #(
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int COLOR_W    = 3,
  parameter int CHECK_LOG2 = 5
) (
  input  logic         clk,
  input  logic         reset,
  vga_timing_if.master vid
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int X_W   = $clog2(H_TOT);
  localparam int Y_W   = $clog2(V_TOT);
  // Counters are widened so the gradient and checker bit selects always exist.
  localparam int PAT_W = (CHECK_LOG2 + 1 > 10) ? CHECK_LOG2 + 1 : 10;
  localparam int HC_W  = (X_W > PAT_W) ? X_W : PAT_W;
  localparam int VC_W  = (Y_W > PAT_W) ? Y_W : PAT_W;
  localparam int BAR_W = H_VIS / 8;
  localparam int BP_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int RGB_W = 3 * COLOR_W;

  localparam logic [HC_W-1:0]    H_LAST   = HC_W'(H_TOT - 1);
  localparam logic [VC_W-1:0]    V_LAST   = VC_W'(V_TOT - 1);
  localparam logic [HC_W-1:0]    H_VIS_C  = HC_W'(H_VIS);
  localparam logic [VC_W-1:0]    V_VIS_C  = VC_W'(V_VIS);
  localparam logic [HC_W-1:0]    HS_BEG   = HC_W'(H_VIS + H_FP);
  localparam logic [HC_W-1:0]    HS_END   = HC_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VC_W-1:0]    VS_BEG   = VC_W'(V_VIS + V_FP);
  localparam logic [VC_W-1:0]    VS_END   = VC_W'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [BP_W-1:0]    BAR_LAST = BP_W'(BAR_W - 1);
  localparam logic [COLOR_W-1:0] C_MAX    = '1;
  localparam logic               HS_ACT   = (HS_POL != 0);
  localparam logic               VS_ACT   = (VS_POL != 0);

  logic [HC_W-1:0]    hc_q, hc_d;
  logic [VC_W-1:0]    vc_q, vc_d;
  logic [BP_W-1:0]    bar_px_q, bar_px_d;
  logic [2:0]         bar_idx_q, bar_idx_d;
  logic [1:0]         mode_q;
  logic [RGB_W-1:0]   rgb_q;
  logic [COLOR_W-1:0] red_q, green_q, blue_q;
  logic               hsync_q, vsync_q, blank_q, fs_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;

  logic               at_origin_s, blank_s, hs_act_s, vs_act_s, chk_s;
  logic [1:0]         mode_eff_s;
  logic [RGB_W-1:0]   rgb_eff_s;
  logic [COLOR_W-1:0] r_s, g_s, b_s;

  // The pattern at (0,0) already uses the inputs being latched on that edge.
  assign at_origin_s = (hc_q == '0) && (vc_q == '0);
  assign mode_eff_s  = at_origin_s ? vid.mode : mode_q;
  assign rgb_eff_s   = at_origin_s ? vid.solid_rgb : rgb_q;
  assign blank_s     = (hc_q >= H_VIS_C) || (vc_q >= V_VIS_C);
  assign hs_act_s    = (hc_q >= HS_BEG) && (hc_q <= HS_END);
  assign vs_act_s    = (vc_q >= VS_BEG) && (vc_q <= VS_END);
  assign chk_s       = hc_q[CHECK_LOG2] ^ vc_q[CHECK_LOG2];

  // Raster counters plus the divider-free bar counter that tracks hc / BAR_W.
  always_comb begin
    hc_d      = hc_q + HC_W'(1);
    vc_d      = vc_q;
    bar_px_d  = bar_px_q + BP_W'(1);
    bar_idx_d = bar_idx_q;
    if (hc_q == H_LAST) begin
      hc_d      = '0;
      bar_px_d  = '0;
      bar_idx_d = 3'd0;
      vc_d      = (vc_q == V_LAST) ? '0 : vc_q + VC_W'(1);
    end else if (bar_px_q == BAR_LAST) begin
      bar_px_d  = '0;
      bar_idx_d = bar_idx_q + 3'd1;
    end else begin
      bar_idx_d = bar_idx_q;
    end
  end

  // Pattern colour for the current counter position, before blanking.
  always_comb begin
    r_s = '0;
    g_s = '0;
    b_s = '0;
    case (mode_eff_s)
      2'd0: {r_s, g_s, b_s} = rgb_eff_s;
      2'd1: begin
        r_s = bar_idx_q[2] ? C_MAX : '0;
        g_s = bar_idx_q[1] ? C_MAX : '0;
        b_s = bar_idx_q[0] ? C_MAX : '0;
      end
      2'd2: begin
        r_s = chk_s ? C_MAX : '0;
        g_s = chk_s ? C_MAX : '0;
        b_s = chk_s ? C_MAX : '0;
      end
      2'd3: begin
        r_s = hc_q[9 -: COLOR_W];
        g_s = vc_q[9 -: COLOR_W];
        b_s = '0;
      end
      default: begin
        r_s = '0;
        g_s = '0;
        b_s = '0;
      end
    endcase
  end

  // State, shadow registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      hc_q      <= '0;
      vc_q      <= '0;
      bar_px_q  <= '0;
      bar_idx_q <= 3'd0;
      mode_q    <= 2'd0;
      rgb_q     <= '0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      hsync_q   <= ~HS_ACT;
      vsync_q   <= ~VS_ACT;
      blank_q   <= 1'b1;
      fs_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      mode_q    <= mode_eff_s;
      rgb_q     <= rgb_eff_s;
      red_q     <= blank_s ? '0 : r_s;
      green_q   <= blank_s ? '0 : g_s;
      blue_q    <= blank_s ? '0 : b_s;
      hsync_q   <= hs_act_s ? HS_ACT : ~HS_ACT;
      vsync_q   <= vs_act_s ? VS_ACT : ~VS_ACT;
      blank_q   <= blank_s;
      fs_q      <= at_origin_s;
      x_q       <= hc_q[X_W-1:0];
      y_q       <= vc_q[Y_W-1:0];
    end
  end

  assign vid.red         = red_q;
  assign vid.green       = green_q;
  assign vid.blue        = blue_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.blank       = blank_q;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.frame_start = fs_q;
endmodule

// File: doc/vga_timing.md
# vga_timing

Parametrised video timing and test-pattern generator. It produces sync, blank, pixel coordinates and a selectable RGB test pattern for any progressive raster; the defaults give 640x480 @ 60 Hz on a 25.175 MHz pixel clock. It sits directly in front of the DVI/TMDS encoder, or a VGA DAC, as the single raster source of the display path. Downstream blocks use its `x`/`y`/`blank` outputs to align their own pixel generation.

## Interface
- `H_VIS`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: hsync pulse width, in pixels.
- `H_BP`, default 48: horizontal back porch, in pixels.
- `V_VIS`, default 480: visible lines per frame.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vsync pulse width, in lines.
- `V_BP`, default 33: vertical back porch, in lines.
- `HS_POL`, default 0: active level of hsync.
- `VS_POL`, default 0: active level of vsync.
- `COLOR_W`, default 3: bits per colour channel.
- `CHECK_LOG2`, default 5: checkerboard square size is 2^CHECK_LOG2 pixels.
- `clk  in  1`: pixel clock.
- `reset  in  1`: synchronous, active-high reset.
- `mode  in  2`: pattern select. 0 = solid, 1 = colour bars, 2 = checkerboard, 3 = gradient.
- `solid_rgb  in  3*COLOR_W`: colour for mode 0, packed as {R,G,B}.
- `red`, `green`, `blue`  out  COLOR_W each: pixel colour.
- `hsync  out  1`: horizontal sync, at `HS_POL` when active.
- `vsync  out  1`: vertical sync, at `VS_POL` when active.
- `blank  out  1`: 1 outside the visible area.
- `x  out  $clog2(H_VIS+H_FP+H_SYNC+H_BP)`: horizontal coordinate of the current output pixel.
- `y  out  $clog2(V_VIS+V_FP+V_SYNC+V_BP)`: vertical coordinate of the current output pixel.
- `frame_start  out  1`: one-cycle pulse, high together with pixel (0,0).

## Operation
- Totals: H_TOT = H_VIS+H_FP+H_SYNC+H_BP; V_TOT is the vertical equivalent.
- Internal counters `hc` and `vc`.
  - `hc` increments every clk and wraps from H_TOT-1 to 0.
  - `vc` increments when `hc` wraps and itself wraps from V_TOT-1 to 0.
- Sync active windows:
  - hsync: `hc` in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], exactly H_SYNC clocks. Defaults: 656..751.
  - vsync: `vc` in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], exactly V_SYNC whole lines. Defaults: 490..491.
  - vsync changes only at `hc`=0.
- `blank` = (`hc` >= H_VIS) or (`vc` >= V_VIS).
- Mode latch: `mode` and `solid_rgb` are sampled into shadow registers only when `hc`=0 and `vc`=0. A pattern change therefore never tears a frame.
- Patterns apply to visible pixels only. While `blank`=1, RGB is all-zero. M = 2^COLOR_W - 1.
  - Mode 0: RGB = latched `solid_rgb`.
  - Mode 1: 8 vertical bars, each H_VIS/8 wide. H_VIS must be divisible by 8. Bar index i = 0..7 from left. R = i[2]?M:0, G = i[1]?M:0, B = i[0]?M:0.
  - Mode 2: white (all channels M) when `hc[CHECK_LOG2]` ^ `vc[CHECK_LOG2]` = 1, otherwise black.
  - Mode 3: R = top COLOR_W bits of `hc`[9:0]; G = top COLOR_W bits of `vc`[9:0]; B = 0.
- The bar index is computed with a per-line bar counter that resets at `hc`=0 and advances every H_VIS/8 pixels. The design contains no divider.

## Timing
- Every output is registered. Outputs for counter state (h,v) appear one clk later, and all outputs stay mutually aligned.
- Reset values, held while `reset`=1:
  - `hc`=`vc`=0
  - `hsync`=!HS_POL, `vsync`=!VS_POL
  - `blank`=1, RGB=0, `x`=0, `y`=0, `frame_start`=0
  - shadow mode = 0, shadow colour = 0
- The shadow registers also load on the first clk after reset deassertion, because the counters are at (0,0).
- First clk edge after reset deasserts: outputs show pixel (0,0) with `frame_start`=1.
- Reset asserted mid-frame: on the next edge, counters return to 0 and outputs take their reset values. No partial sync pulse continues.
- Frame period is H_TOT*V_TOT clks; `frame_start` fires exactly once per frame.
- Sync windows that straddle the wrap point are not supported (H_FP+H_SYNC+H_BP and the vertical sum must be ≥1 each).

## Test plan
- Reset: hold `reset` for 5 clks, then release. Required:
  - during reset, hsync=vsync=1, blank=1, RGB=0 (defaults);
  - first post-reset output is x=0, y=0, frame_start=1, blank=0.
- Horizontal timing, defaults: hsync low for exactly 96 clks with x=656..751; line period 800 clks; blank high for x=640..799.
- Vertical timing: vsync low for exactly 2×800 clks on y=490..491; frame_start period 420000 clks; blank high for all of y≥480.
- Colour bars, mode=1, COLOR_W=3:
  - x=0 gives RGB 000/000/000;
  - x=80 gives 000/000/111;
  - x=639 gives 111/111/111;
  - x=640 gives 0 with blank=1.
- Mode change at y=100: switch 0→2. Required: the remainder of that frame stays solid; the checkerboard starts at frame_start; pixel (32,0) is white and (32,32) is black.
- Small raster (H 8/2/3/1, V 4/1/1/1, i.e. H_TOT 14, V_TOT 7): check x/y wrap-around, exact sync positions, and a mid-line reset returning to (0,0) on the next edge.
